approx_mult_core: RTL and testbench
===================================

# approx_mult_core

Datapath stage directly downstream of the load/normalize/shift controller. It accepts one pair of W-bit unsigned operands through a valid/ready handshake. Each operand is normalized by shifting left one bit per cycle until it has a leading one, and the two top-M-bit mantissas are multiplied. The product is rescaled to a 2W-bit approximate result, which is held until the consumer (the result-RAM write stage) accepts it.

## Interface
- W, 16, operand width (W ≥ M+1)
- M, 8, mantissa bits kept after normalization
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  W  operand A, unsigned
- b  in  W  operand B, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  2W  approximate product, unsigned
- busy  out  1  high in every state except IDLE

## Operation
- States are IDLE, NORM, MULT, SCALE and DONE.
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready: load sa←a, sb←b, ca←0, cb←0, then go to NORM.
- NORM
  - Per operand X: doneX = sX[W-1] | (cX == W-1). Both flags are combinational on the current registers.
  - If !doneX: sX ← sX<<1 and cX ← cX+1.
  - If doneA & doneB: go to MULT.
  - The two operands shift independently in the same cycle.
  - The count saturates at W-1, so a zero operand stops with cX = W-1 and sX = 0.
- MULT
  - p ← sa[W-1:W-M] * sb[W-1:W-M], 2M bits unsigned. Go to SCALE.
- SCALE
  - s = ca+cb is computed with width ≥ log2(2W-1)+1 bits.
  - If s ≤ 2(W-M): result ← p << (2(W-M) − s), zero-extended to 2W bits.
  - Else: result ← p >> (s − 2(W-M)), a truncating right shift.
  - Go to DONE.
- DONE
  - out_valid = 1. result is held stable.
  - On out_ready: go to IDLE.
- Accuracy
  - Operands with at most M significant bits are exact.
  - Larger operands are truncated to their top M significant bits, with no rounding.
- result is registered and changes only on the SCALE→DONE edge and on reset.

## Timing
- Reset (rst = 0, asynchronous):
  - state = IDLE, result = 0, out_valid = 0, busy = 0.
  - sa, sb, ca and cb are cleared.
  - in_ready = 1, but inputs are ignored until rst is deasserted.
- Latency: out_valid rises max(ca_final, cb_final)+3 cycles after the accept edge.
  - Breakdown: NORM lasts max+1 cycles, then 1 cycle each for MULT and SCALE.
  - Minimum 3 cycles (both MSBs already set). Maximum W+2 cycles.
- Handshake rules:
  - in_ready is low from the accept edge until DONE→IDLE.
  - The accept edge is the edge on which in_valid & in_ready is sampled high.
  - There is no accept in the same cycle as the out_ready handshake, so the next accept is ≥ 1 cycle after out_valid falls.
  - out_valid is held indefinitely under back-pressure. result does not change while out_valid = 1.
  - out_ready while not in DONE is ignored.
  - a and b are sampled only on the accept edge. Changes afterwards have no effect.
- Boundary cases:
  - Operand = 0: its count runs to W-1, its mantissa is 0, and result = 0.
  - Both operands = 0: result = 0 after W+2 cycles.
  - Operand = 1: count W-1, mantissa 2^(M-1).
- Reset mid-operation (any state): the block returns to IDLE immediately and the partial operation is discarded. out_valid drops asynchronously.

## Test plan
- Reset released, a=3, b=5, in_valid pulsed → accept, out_valid after 17 cycles (max count 14), result = 32'h0000_000F. busy high for the whole operation.
- a=16'hFFFF, b=16'hFFFF → out_valid exactly 3 cycles after accept, result = 32'hFE01_0000.
- a=16'h1234, b=1 → counts are 3 and 15, result = 32'h0000_1220 (truncated), latency 18 cycles.
- a=0, b=16'h1234 → result = 0. a=0, b=0 → result = 0 after W+2 cycles.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE → out_valid and result stable, in_ready=0. Raise out_ready → IDLE next cycle. A new in_valid is accepted only from then on.
- Assert rst mid-NORM → out_valid=0 and result=0 immediately, busy=0. After release, a new operation with a=7, b=9 gives result = 63.

Source files
------------

// File: rtl/approx_mult_core_if.sv
// Handshake bundle between the normalizer feed, the approximate multiplier
// and the result-RAM write stage. The master side drives operands and
// out_ready. The slave side (the core) drives in_ready, the result and status.
interface approx_mult_core_if #(
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/approx_mult_core.sv
// Approximate unsigned multiplier. Both operands are normalized by shifting
// left one bit per cycle until the MSB is set, with a count that saturates at
// W-1. The top M bits of each operand are multiplied. The product is then
// rescaled by the combined shift count into a 2W-bit result. That result is
// held until the consumer accepts it.
module approx_mult_core #(
    parameter int W = 16,
    parameter int M = 8
) (
    input  logic              clk,
    input  logic              rst,
    approx_mult_core_if.slave bus
);
    localparam int CW        = $clog2(W);
    localparam int SW        = $clog2(2 * W) + 1;
    localparam int SHIFT_REF = 2 * (W - M);

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        MULT,
        SCALE,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    sa_q, sa_d;
    logic [W-1:0]    sb_q, sb_d;
    logic [CW-1:0]   ca_q, ca_d;
    logic [CW-1:0]   cb_q, cb_d;
    logic [2*M-1:0]  p_q, p_d;
    logic [2*W-1:0]  result_q, result_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic            done_a;
    logic            done_b;
    logic [SW-1:0]   shift_sum;
    logic [SW-1:0]   shift_ref;
    logic [2*W-1:0]  p_ext;

    // A zero operand never gains a leading one. The saturated count ends its normalization.
    assign done_a    = sa_q[W-1] | (ca_q == CW'(W - 1));
    assign done_b    = sb_q[W-1] | (cb_q == CW'(W - 1));
    assign shift_sum = {{(SW - CW){1'b0}}, ca_q} + {{(SW - CW){1'b0}}, cb_q};
    assign shift_ref = SW'(SHIFT_REF);
    assign p_ext     = {{(2 * W - 2 * M){1'b0}}, p_q};

    // Next-state and next-output computation for the whole operation sequence.
    always_comb begin
        state_d     = state_q;
        sa_d        = sa_q;
        sb_d        = sb_q;
        ca_d        = ca_q;
        cb_d        = cb_q;
        p_d         = p_q;
        result_d    = result_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    sa_d       = bus.a;
                    sb_d       = bus.b;
                    ca_d       = '0;
                    cb_d       = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = NORM;
                end
            end
            NORM: begin
                if (!done_a) begin
                    sa_d = sa_q << 1;
                    ca_d = ca_q + CW'(1);
                end
                if (!done_b) begin
                    sb_d = sb_q << 1;
                    cb_d = cb_q + CW'(1);
                end
                if (done_a && done_b) begin
                    state_d = MULT;
                end
            end
            MULT: begin
                p_d     = {{M{1'b0}}, sa_q[W-1:W-M]} * {{M{1'b0}}, sb_q[W-1:W-M]};
                state_d = SCALE;
            end
            SCALE: begin
                if (shift_sum <= shift_ref) begin
                    result_d = p_ext << (shift_ref - shift_sum);
                end else begin
                    result_d = p_ext >> (shift_sum - shift_ref);
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and registered outputs. Reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            sa_q        <= '0;
            sb_q        <= '0;
            ca_q        <= '0;
            cb_q        <= '0;
            p_q         <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sa_q        <= sa_d;
            sb_q        <= sb_d;
            ca_q        <= ca_d;
            cb_q        <= cb_d;
            p_q         <= p_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_approx_mult_core.sv
// Testbench for approx_mult_core. Expected results and latencies are queued
// when operands are driven. They are popped and compared when out_valid appears.
module tb_approx_mult_core;
    localparam int W = 16;
    localparam int M = 8;

    typedef struct {
        logic [2*W-1:0] res;
        int             lat;
    } exp_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   fails;
    exp_t sb_q[$];

    approx_mult_core_if #(.W(W)) bus ();

    approx_mult_core #(.W(W), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour: leading-one search, truncated mantissas, rescale.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t           e;
        int             cx, cy, s;
        logic [W-1:0]   nx, ny;
        logic [2*M-1:0] p;
        logic [2*W-1:0] pe;
        cx = W - 1;
        cy = W - 1;
        for (int i = 0; i < W; i++) begin
            if (x[i]) cx = W - 1 - i;
            if (y[i]) cy = W - 1 - i;
        end
        nx = x << cx;
        ny = y << cy;
        p  = {{M{1'b0}}, nx[W-1:W-M]} * {{M{1'b0}}, ny[W-1:W-M]};
        pe = {{(2*W-2*M){1'b0}}, p};
        s  = cx + cy;
        if (s <= 2 * (W - M)) e.res = pe << (2 * (W - M) - s);
        else                  e.res = pe >> (s - 2 * (W - M));
        e.lat = ((cx > cy) ? cx : cy) + 3;
        return e;
    endfunction

    // One full operation: accept, wait for result, check latency/result, release.
    task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v,
                          input logic [2*W-1:0] exp_res, input int exp_lat,
                          input bit early_ready);
        exp_t e;
        int   cycles;
        bit   got;
        bit   busy_ok;
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL idle_in_ready a=%h b=%h: got %b want 1", a_v, b_v, bus.in_ready);
        end
        bus.a        = a_v;
        bus.b        = b_v;
        bus.in_valid = 1'b1;
        sb_q.push_back('{res: exp_res, lat: exp_lat});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = ~a_v;
        bus.b        = ~b_v;
        if (early_ready) bus.out_ready = 1'b1;
        tests_run++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL accept_flags a=%h b=%h: in_ready=%b busy=%b want 0/1",
                     a_v, b_v, bus.in_ready, bus.busy);
        end
        cycles  = 0;
        got     = 0;
        busy_ok = 1;
        while (!got && cycles < W + 10) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.out_valid === 1'b1) got = 1;
            else if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) busy_ok = 0;
        end
        e = sb_q.pop_front();
        tests_run++;
        if (!got) begin
            fails++;
            $display("[TB] FAIL timeout a=%h b=%h: no out_valid after %0d cycles", a_v, b_v, cycles);
            bus.out_ready = 1'b0;
            return;
        end
        if (cycles != e.lat) begin
            fails++;
            $display("[TB] FAIL latency a=%h b=%h: got %0d want %0d", a_v, b_v, cycles, e.lat);
        end
        tests_run++;
        if (bus.result !== e.res) begin
            fails++;
            $display("[TB] FAIL result a=%h b=%h: got %h want %h", a_v, b_v, bus.result, e.res);
        end
        tests_run++;
        if (!busy_ok) begin
            fails++;
            $display("[TB] FAIL busy_during_op a=%h b=%h: busy/in_ready not held", a_v, b_v);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL release a=%h b=%h: out_valid=%b in_ready=%b busy=%b want 0/1/0",
                     a_v, b_v, bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    // Reset values, and inputs ignored while reset is held.
    task automatic test_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.result !== '0) begin
            fails++;
            $display("[TB] FAIL reset_out: out_valid=%b result=%h want 0/0", bus.out_valid, bus.result);
        end
        tests_run++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_status: busy=%b in_ready=%b want 0/1", bus.busy, bus.in_ready);
        end
        bus.a        = 16'h00FF;
        bus.b        = 16'h00FF;
        bus.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_ignores_input: busy=%b in_ready=%b want 0/1", bus.busy, bus.in_ready);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Hand-derived vectors, including zero and one operands.
    task automatic test_known_vectors();
        logic [W-1:0]   va[6]   = '{16'h0003, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 16'h0007};
        logic [W-1:0]   vb[6]   = '{16'h0005, 16'hFFFF, 16'h0001, 16'h1234, 16'h0000, 16'h0009};
        logic [2*W-1:0] vr[6]   = '{32'h0000_000F, 32'hFE01_0000, 32'h0000_1220,
                                    32'h0000_0000, 32'h0000_0000, 32'h0000_003F};
        int             vl[6]   = '{17, 3, 18, 18, 18, 16};
        for (int i = 0; i < 6; i++) begin
            run_op(va[i], vb[i], vr[i], vl[i], 1'b0);
        end
    endtask

    // Random operands of varied magnitude against the reference model.
    task automatic test_random();
        logic [W-1:0] x, y;
        exp_t         e;
        for (int i = 0; i < 8; i++) begin
            x = W'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            y = W'($urandom_range(0, 65535) >> $urandom_range(0, 15));
            e = model(x, y);
            run_op(x, y, e.res, e.lat, i[0]);
        end
    endtask

    // Result held under back-pressure, and no accept on the release edge.
    task automatic test_backpressure();
        exp_t e;
        int   cycles;
        bit   got;
        bit   hold_ok;
        bus.a        = 16'h0003;
        bus.b        = 16'h0005;
        bus.in_valid = 1'b1;
        sb_q.push_back('{res: 32'h0000_000F, lat: 17});
        @(posedge clk);
        #1;
        bus.a = 16'hFFFF;
        bus.b = 16'hFFFF;
        cycles = 0;
        got    = 0;
        while (!got && cycles < W + 10) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.out_valid === 1'b1) got = 1;
        end
        e = sb_q.pop_front();
        tests_run++;
        if (!got || bus.result !== e.res) begin
            fails++;
            $display("[TB] FAIL bp_first_result: valid=%b result=%h want 1/%h", got, bus.result, e.res);
        end
        hold_ok = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.result !== e.res || bus.in_ready !== 1'b0) hold_ok = 0;
        end
        tests_run++;
        if (!hold_ok) begin
            fails++;
            $display("[TB] FAIL bp_hold: out_valid=%b result=%h in_ready=%b want 1/%h/0",
                     bus.out_valid, bus.result, bus.in_ready, e.res);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_release: in_ready=%b out_valid=%b busy=%b want 1/0/0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
        sb_q.push_back('{res: 32'hFE01_0000, lat: 3});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_next_accept: busy=%b in_ready=%b want 1/0", bus.busy, bus.in_ready);
        end
        cycles = 0;
        got    = 0;
        while (!got && cycles < W + 10) begin
            @(posedge clk);
            #1;
            cycles++;
            if (bus.out_valid === 1'b1) got = 1;
        end
        e = sb_q.pop_front();
        tests_run++;
        if (!got || cycles != e.lat || bus.result !== e.res) begin
            fails++;
            $display("[TB] FAIL bp_second_op: cycles=%0d result=%h want %0d/%h",
                     cycles, bus.result, e.lat, e.res);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    // Asynchronous reset during normalization discards the operation.
    task automatic test_reset_midop();
        bus.a        = 16'h0000;
        bus.b        = 16'h0000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midop_reset: out_valid=%b result=%h busy=%b want 0/0/0",
                     bus.out_valid, bus.result, bus.busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_op(16'h0007, 16'h0009, 32'd63, 16, 1'b0);
    endtask

    // Consecutive operations with no idle gap, early out_ready on some.
    task automatic test_back_to_back();
        logic [W-1:0] xs[4] = '{16'h8000, 16'h0101, 16'h00F0, 16'h7FFF};
        logic [W-1:0] ys[4] = '{16'h0002, 16'h4000, 16'h0003, 16'h0000};
        exp_t         e;
        for (int i = 0; i < 4; i++) begin
            e = model(xs[i], ys[i]);
            run_op(xs[i], ys[i], e.res, e.lat, i[0]);
        end
    endtask

    // Test sequence.
    initial begin
        tests_run     = 0;
        fails         = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        test_reset();
        test_known_vectors();
        test_random();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
